// File: rtl/featuremap_conv_ctrl_if.sv
// rtl/featuremap_conv_ctrl_if.sv - handshake bundle between frame controller, channel FIFOs and conv filter
//   start, fifo_empty[7:0], conv_valid : into the controller
//   rdreq, pad_sel, pix_valid          : FIFO read / filter input control out of the controller
//   out_valid, busy, done              : output qualification and frame status out of the controller
interface featuremap_conv_ctrl_if;
  logic       start;
  logic [7:0] fifo_empty;
  logic       conv_valid;
  logic       rdreq;
  logic       pad_sel;
  logic       pix_valid;
  logic       out_valid;
  logic       busy;
  logic       done;

  modport master (
    input  start, fifo_empty, conv_valid,
    output rdreq, pad_sel, pix_valid, out_valid, busy, done
  );

  modport slave (
    output start, fifo_empty, conv_valid,
    input  rdreq, pad_sel, pix_valid, out_valid, busy, done
  );
endinterface

// File: rtl/featuremap_conv_ctrl.sv
// rtl/featuremap_conv_ctrl.sv - padded-frame feed and output qualification controller
//   clk, rst : clock and synchronous active-high reset
//   bus      : featuremap_conv_ctrl_if.master (start/fifo_empty/conv_valid in; rdreq/pad_sel/
//              pix_valid/out_valid/busy/done out)
// Walks a (HEIGHT+2)x(WIDTH+2) zero-padded frame, reading all 8 channel FIFOs together on
// interior pixels, then counts filter results and drops the wrap-around columns.
module featuremap_conv_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                   clk,
  input  logic                   rst,
  featuremap_conv_ctrl_if.master bus
);

  // Pixel data never passes through this block; the width only has to be sane.
  if (DATA_WIDTH < 1) begin : g_invalid_data_width
    logic never_used;
    assign never_used = 1'b0;
  end

  localparam int RW = $clog2(HEIGHT + 2);
  localparam int CW = $clog2(WIDTH + 2);
  localparam int OW = $clog2(HEIGHT * WIDTH + 1);

  localparam logic [RW-1:0] R_LAST  = RW'(HEIGHT + 1);
  localparam logic [CW-1:0] C_LAST  = CW'(WIDTH + 1);
  localparam logic [CW-1:0] C_REAL  = CW'(WIDTH);
  localparam logic [OW-1:0] OC_LAST = OW'(HEIGHT * WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [CW-1:0] ocol_q, ocol_d;
  logic [OW-1:0] oc_q, oc_d;

  logic in_feed, active, pad_pos, all_ready;
  logic rdreq_i, pad_sel_i, pix_valid_i, out_valid_i, done_i;

  always_comb begin
    in_feed   = (state_q == S_FEED);
    active    = (state_q == S_FEED) || (state_q == S_DRAIN);
    pad_pos   = (r_q == '0) || (r_q == R_LAST) || (c_q == '0) || (c_q == C_LAST);
    // All eight channels must have data; a partial read would desync the channels.
    all_ready = (bus.fifo_empty == 8'h00);

    pad_sel_i   = in_feed && pad_pos;
    pix_valid_i = in_feed && (pad_pos || all_ready);
    rdreq_i     = in_feed && !pad_pos && all_ready;

    // The last two columns of each output row are windows straddling the row wrap.
    out_valid_i = active && bus.conv_valid && (ocol_q < C_REAL);
    done_i      = out_valid_i && (oc_q == OC_LAST);
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    ocol_d  = ocol_q;
    oc_d    = oc_q;

    if (state_q == S_IDLE) begin
      if (bus.start) begin
        state_d = S_FEED;
        r_d     = '0;
        c_d     = '0;
        ocol_d  = '0;
        oc_d    = '0;
      end
    end else if (active) begin
      if (bus.conv_valid) begin
        ocol_d = (ocol_q == C_LAST) ? '0 : ocol_q + CW'(1);
      end
      if (out_valid_i) begin
        oc_d = oc_q + OW'(1);
      end
      if (in_feed && pix_valid_i) begin
        if (c_q == C_LAST) begin
          c_d = '0;
          if (r_q == R_LAST) begin
            // Last padded position issued: park r at 0 so it never exceeds HEIGHT+1.
            r_d     = '0;
            state_d = S_DRAIN;
          end else begin
            r_d = r_q + RW'(1);
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      // The final real output ends the frame even if feeding has not finished.
      if (done_i) begin
        state_d = S_IDLE;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      ocol_q  <= '0;
      oc_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      ocol_q  <= ocol_d;
      oc_q    <= oc_d;
    end
  end

  // Reset masks the combinational outputs so nothing leaks during the reset cycle itself.
  assign bus.rdreq     = rdreq_i && !rst;
  assign bus.pad_sel   = pad_sel_i && !rst;
  assign bus.pix_valid = pix_valid_i && !rst;
  assign bus.out_valid = out_valid_i && !rst;
  assign bus.done      = done_i && !rst;
  assign bus.busy      = active && !rst;

endmodule

// File: tb/tb_featuremap_conv_ctrl.sv
// tb/tb_featuremap_conv_ctrl.sv - randomized and directed bench for featuremap_conv_ctrl
module tb_featuremap_conv_ctrl;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = W + 2;
  localparam int NPOS = (H + 2) * (W + 2);

  logic clk = 1'b0;
  logic rst = 1'b1;

  featuremap_conv_ctrl_if bus();

  featuremap_conv_ctrl #(.DATA_WIDTH(32), .WIDTH(W), .HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position as a linear raster index, results as a pulse count.
  bit m_busy = 1'b0;
  bit m_feed = 1'b0;
  int m_p    = 0;
  int m_n    = 0;
  int m_oc   = 0;

  always @(negedge clk) begin : compare
    int  r, c;
    bit  padpos, ready;
    bit  e_pad, e_pix, e_rd, e_ov, e_done, e_busy;
    r      = m_p / PW;
    c      = m_p % PW;
    padpos = (r == 0) || (r == H + 1) || (c == 0) || (c == W + 1);
    ready  = (bus.fifo_empty == 8'h00);
    e_pad  = !rst && m_feed && padpos;
    e_pix  = !rst && m_feed && (padpos || ready);
    e_rd   = !rst && m_feed && !padpos && ready;
    e_ov   = !rst && m_busy && bus.conv_valid && ((m_n % PW) < W);
    e_done = e_ov && (m_oc == H * W - 1);
    e_busy = !rst && m_busy;

    chk("pad_sel",   bus.pad_sel,   e_pad);
    chk("pix_valid", bus.pix_valid, e_pix);
    chk("rdreq",     bus.rdreq,     e_rd);
    chk("out_valid", bus.out_valid, e_ov);
    chk("done",      bus.done,      e_done);
    chk("busy",      bus.busy,      e_busy);

    if (rst) begin
      m_busy = 1'b0; m_feed = 1'b0; m_p = 0; m_n = 0; m_oc = 0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy = 1'b1; m_feed = 1'b1; m_p = 0; m_n = 0; m_oc = 0;
      end
    end else begin
      if (bus.conv_valid) m_n++;
      if (e_ov) m_oc++;
      if (e_done) begin
        m_busy = 1'b0; m_feed = 1'b0;
      end else if (m_feed && e_pix) begin
        if (m_p == NPOS - 1) m_feed = 1'b0;
        else m_p++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a frame and observes 70 cycles of feeding.
  task automatic run_frame(input bit stall_en, input bit hold_start,
                           output int npv, output int nrd, output int npad,
                           output int nfirst, output int span, output bit rd_resume);
    int first, last;
    npv = 0; nrd = 0; npad = 0; nfirst = 0; first = -1; last = -1; rd_resume = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 70; i++) begin
      bus.fifo_empty = (stall_en && i >= 7 && i < 17) ? 8'h20 : 8'h00;
      bus.start      = hold_start && i >= 3 && i < 11;
      @(negedge clk);
      if (bus.pix_valid) begin
        npv++;
        if (first < 0) first = i;
        last = i;
      end
      if (bus.rdreq) nrd++;
      if (bus.pad_sel) begin
        npad++;
        if (i < 7) nfirst++;
      end
      if (i == 17) rd_resume = bus.rdreq;
      tick();
    end
    bus.fifo_empty = 8'h00;
    bus.start      = 1'b0;
    span = last - first + 1;
  endtask

  // Drives 36 back-to-back conv_valid pulses.
  task automatic drain(input bit start_on_done, output bit [35:0] pat,
                       output int dn_idx, output int nov);
    pat = '0; dn_idx = -1; nov = 0;
    for (int k = 0; k < 36; k++) begin
      bus.conv_valid = 1'b1;
      bus.start      = start_on_done && (k == 21);
      @(negedge clk);
      pat[k] = bus.out_valid;
      if (bus.out_valid) nov++;
      if (bus.done) dn_idx = k;
      tick();
    end
    bus.conv_valid = 1'b0;
    bus.start      = 1'b0;
  endtask

  int npv, nrd, npad, nfirst, span, dn_idx, nov;
  bit rd_resume;
  bit [35:0] pat;
  bit [35:0] exp_pat;

  initial begin
    exp_pat = 36'h0003CF3CF;
    bus.start = 1'b0;
    bus.fifo_empty = 8'h00;
    bus.conv_valid = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_rdreq", bus.rdreq, 1'b0);
    chk("reset_pix_valid", bus.pix_valid, 1'b0);
    tick();

    // Clean frame
    run_frame(1'b0, 1'b0, npv, nrd, npad, nfirst, span, rd_resume);
    chk("a_feed_len", span, 36);
    chk("a_pix_valid", npv, 36);
    chk("a_reads", nrd, 16);
    chk("a_pads", npad, 20);
    chk("a_first_pads", nfirst, 7);
    drain(1'b0, pat, dn_idx, nov);
    chk("a_out_pattern", pat, exp_pat);
    chk("a_out_count", nov, 16);
    chk("a_done_idx", dn_idx, 21);
    @(negedge clk);
    chk("a_idle_after", bus.busy, 1'b0);
    tick();

    // Stall on bit 5 at the first interior pixel
    run_frame(1'b1, 1'b0, npv, nrd, npad, nfirst, span, rd_resume);
    chk("b_feed_len", span, 46);
    chk("b_pix_valid", npv, 36);
    chk("b_reads", nrd, 16);
    chk("b_pads", npad, 20);
    chk("b_resume_read", rd_resume, 1'b1);
    drain(1'b0, pat, dn_idx, nov);
    chk("b_done_idx", dn_idx, 21);
    tick();

    // Mid-frame reset at r=3,c=2
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("c_busy_after_rst", bus.busy, 1'b0);
    chk("c_rdreq_after_rst", bus.rdreq, 1'b0);
    tick();
    run_frame(1'b0, 1'b0, npv, nrd, npad, nfirst, span, rd_resume);
    chk("c_feed_len", span, 36);
    chk("c_reads", nrd, 16);
    chk("c_first_pads", nfirst, 7);
    drain(1'b0, pat, dn_idx, nov);
    chk("c_done_idx", dn_idx, 21);
    tick();

    // Start during FEED and on the done cycle; conv_valid afterwards lands in IDLE
    run_frame(1'b0, 1'b1, npv, nrd, npad, nfirst, span, rd_resume);
    chk("d_feed_len", span, 36);
    chk("d_reads", nrd, 16);
    drain(1'b1, pat, dn_idx, nov);
    chk("d_out_pattern", pat, exp_pat);
    chk("d_done_idx", dn_idx, 21);
    @(negedge clk);
    chk("d_no_restart", bus.busy, 1'b0);
    tick();

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 499) == 0);
      bus.start      = ($urandom_range(0, 19) == 0);
      bus.fifo_empty = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      bus.conv_valid = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst = 1'b0;
    bus.start = 1'b0;
    bus.conv_valid = 1'b0;
    bus.fifo_empty = 8'h00;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/featuremap_conv_ctrl.md
FEATUREMAP_CONV_CTRL -- requirements
Module: featuremap_conv_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, pixel word width in bits; the block carries no pixel data and uses it only for documentation consistency.
REQ-002 Parameter WIDTH, default 56, unpadded feature-map width in pixels.
REQ-003 Parameter HEIGHT, default 56, unpadded feature-map height in pixels.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to process one frame; sampled only in IDLE.
REQ-007 fifo_empty  input  8  per-channel input FIFO empty flags; bit n is channel n.
REQ-008 conv_valid  input  1  valid_out pulse from the filter's bias adder, one per window result.
REQ-009 rdreq  output  1  common read request to all 8 channel FIFOs (show-ahead FIFOs).
REQ-010 pad_sel  output  1  1 = filter inputs take zero instead of FIFO data this cycle.
REQ-011 pix_valid  output  1  drives valid_in of all 8 conv2D line buffers.
REQ-012 out_valid  output  1  conv_valid qualified to real (non-wrap) output positions.
REQ-013 busy  output  1  high from accepted start until done.
REQ-014 done  output  1  one-cycle pulse when the last real output of the frame is seen.

Function
REQ-015 State machine SHALL have states IDLE, FEED, DRAIN, with registered state.
REQ-016 IDLE -> FEED on start=1; row counter r and column counter c SHALL load 0, output counter oc, output column ocol SHALL load 0.
REQ-017 In FEED the block SHALL walk the padded frame r = 0..HEIGHT+1, c = 0..WIDTH+1, raster order, c wrapping to 0 and r incrementing after c = WIDTH+1.
REQ-018 Pad position: r=0, r=HEIGHT+1, c=0 or c=WIDTH+1; there pad_sel=1, pix_valid=1, rdreq=0, and the position advances every cycle unconditionally.
REQ-019 Interior position: when fifo_empty == 8'h00, rdreq=1, pix_valid=1, pad_sel=0, and the position advances; otherwise rdreq=0, pix_valid=0, and the position holds.
REQ-020 rdreq, pix_valid, pad_sel SHALL be combinational from state, r, c, fifo_empty (zero-latency to the FIFO read); all three SHALL be 0 outside FEED.
REQ-021 rdreq SHALL never assert while any fifo_empty bit is 1; partial reads of a subset of channels are forbidden.
REQ-022 After position (HEIGHT+1, WIDTH+1) is issued, FEED -> DRAIN on the same edge.
REQ-023 In FEED and DRAIN, each conv_valid=1 SHALL advance ocol, wrapping at WIDTH+2 (0..WIDTH+1); out_valid = conv_valid AND ocol < WIDTH, combinational.
REQ-024 oc SHALL increment on each out_valid; width ceil(log2(HEIGHT*WIDTH+1)) bits.
REQ-025 When out_valid=1 and oc = HEIGHT*WIDTH-1, done SHALL pulse for that cycle and the state SHALL go to IDLE on the next edge, from either FEED or DRAIN.
REQ-026 conv_valid in IDLE SHALL be ignored: out_valid=0, counters unchanged.
REQ-027 start while busy=1 SHALL be ignored; start in the same cycle as done SHALL be ignored (state still leaving FEED/DRAIN).
REQ-028 busy = 1 in FEED and DRAIN, 0 in IDLE.
REQ-029 Counters SHALL not overflow: c, r, ocol never exceed WIDTH+1, HEIGHT+1, WIDTH+1 respectively.

Reset
REQ-030 rst=1 at any edge, including mid-frame, SHALL force IDLE, r=c=ocol=oc=0; outputs during/after reset: rdreq=0, pix_valid=0, pad_sel=0, out_valid=0, busy=0, done=0.
REQ-031 rst SHALL take priority over start and conv_valid in the same cycle.

Verification (WIDTH=4, HEIGHT=4)
REQ-032 Reset, then start with fifo_empty=8'h00 constant -> FEED lasts exactly 36 cycles, pix_valid=1 all 36, rdreq=1 on exactly 16, pad_sel=1 on 20; first 7 cycles pad_sel=1.
REQ-033 Same, fifo_empty bit 5 held 1 for 10 cycles at first interior position (r=1,c=1) -> rdreq=0, pix_valid=0, r/c frozen 10 cycles; FEED then lasts 46 cycles total, still 16 reads.
REQ-034 Drive 36 conv_valid pulses -> out_valid on 16 of them, pattern per 6-pulse group 1,1,1,1,0,0; done pulses with the 16th out_valid; IDLE next cycle.
REQ-035 rst=1 asserted at r=3,c=2 -> next cycle busy=0, rdreq=0; new start runs full 36-cycle frame from r=0,c=0.
REQ-036 start asserted during FEED and on done cycle -> no restart; busy falls after done; conv_valid in IDLE -> out_valid stays 0.
